collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Consumes the per-pixel obstacle coordinates (obstacle_x/obstacle_y) that all obstacle generators drive each cycle, OR-ed together upstream.
- Compares them against a cursor box latched from the mouse position, then manages player HP, a post-hit invulnerability window counted in frames, and the game_over flag.
- Sits between the obstacle generators and the game-control/menu logic.

Parameters:
- CURSOR_W, 12, cursor box width in pixels.
- CURSOR_H, 12, cursor box height in pixels.
- HP_MAX, 3, HP loaded on arm/restart (1..15).
- INVULN_FRAMES, 60, frames of invulnerability after a hit (1..255).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- hcount_in  in  12  current pixel column.
- vcount_in  in  12  current pixel row.
- obstacle_x  in  12  obstacle pixel x; 0 with obstacle_y=0 means no obstacle pixel.
- obstacle_y  in  12  obstacle pixel y.
- mouse_xpos  in  12  cursor left edge.
- mouse_ypos  in  12  cursor top edge.
- game_on  in  1  level; high while a round is active.
- restart  in  1  one-cycle pulse; reloads HP and re-arms.
- hit  out  1  one-cycle pulse per accepted hit.
- hp  out  4  remaining HP.
- invulnerable  out  1  high during the invulnerability window.
- game_over  out  1  high when HP reaches 0; held.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hit=0, hp=HP_MAX, invulnerable=0, game_over=0, latched cursor=(0,0), frame counter=0.
- Frame tick: asserted on the cycle where hcount_in==0 and vcount_in==0.
  - On each tick, mouse_xpos/mouse_ypos are latched into cursor registers.
  - All comparisons use the latched values, so there is no tearing within a frame.
- Overlap (combinational, 13-bit arithmetic, no wrap):
  - (obstacle_x|obstacle_y)!=0
  - obstacle_x >= cx and obstacle_x <= cx+CURSOR_W-1
  - obstacle_y >= cy and obstacle_y <= cy+CURSOR_H-1
  - cx=4090 with W=12 must still match x=4095.
- State IDLE:
  - hp=HP_MAX, outputs low.
  - game_on=1 -> ARMED.
- State ARMED:
  - Overlap -> hit=1 on the next cycle (latency 1).
  - hp decrements by 1 on that same next edge.
  - If new hp==0 -> DEAD; otherwise -> INVULN with counter=INVULN_FRAMES.
- State INVULN:
  - invulnerable=1; overlaps ignored, no hit.
  - Counter decrements on each frame tick; at 0 -> ARMED, invulnerable=0 on that edge.
  - A tick on the load cycle does not decrement.
- State DEAD:
  - game_over=1 held, hp=0, overlaps ignored.
- Any state with game_on=0 -> IDLE next edge: hp reloads, game_over clears.
- restart=1 in any state: hp=HP_MAX, game_over=0, invulnerable=0, counter=0.
  - Then -> ARMED if game_on=1, else IDLE.
- Priority: reset > game_on=0 > restart > hit.
  - Restart and overlap in the same cycle: restart wins, no hit, no decrement.
- At most one HP decrement per hit.
  - Multiple overlapping pixels in one frame count once, because INVULN is entered immediately.
- hp never underflows below 0.

Optional Feature:
- Macro: COLLISION_GOD_MODE_EN.
- Defined:
  - hit pulses and INVULN entry behave normally.
  - hp is never decremented; DEAD is unreachable; game_over stays 0.
- Undefined: behaviour exactly as above.

Test Plan:
- Reset then game_on=1: hp=3, state ARMED, hit=0, game_over=0.
- Latch mouse (100,200) at tick; drive obstacle (105,205) one cycle -> hit=1 one cycle later, hp=2, invulnerable=1.
- Same setup; obstacle (112,205) -> no hit (x outside 100..111); obstacle (111,211) -> hit.
- INVULN_FRAMES=2: hit, then obstacle overlaps every cycle -> no further hits until 2 frame ticks pass; next overlap after re-arm -> hp=1.
- Three spaced hits -> third hit gives hp=0, game_over=1 held; restart pulse -> hp=3, game_over=0, state ARMED.
- Restart and overlap in the same cycle -> hit=0, hp=3; game_on dropped mid-INVULN -> IDLE, invulnerable=0 next edge.

Source files
------------

// File: rtl/collision_detector.sv
// Cursor/obstacle collision detector with HP, frame-counted invulnerability and game-over tracking.
// Optional COLLISION_GOD_MODE_EN: hits still pulse and start invulnerability, but HP never drops.
module collision_detector #(
  parameter int CURSOR_W      = 12,
  parameter int CURSOR_H      = 12,
  parameter int HP_MAX        = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        game_on,
  input  logic        restart,
  output logic        hit,
  output logic [3:0]  hp,
  output logic        invulnerable,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, ARMED, INVULN, DEAD} state_t;

  localparam logic [3:0]  HP_LOAD     = 4'(HP_MAX);
  localparam logic [7:0]  FRAMES_LOAD = 8'(INVULN_FRAMES);
  localparam logic [12:0] W_SPAN      = 13'(CURSOR_W - 1);
  localparam logic [12:0] H_SPAN      = 13'(CURSOR_H - 1);

  state_t      state;
  logic [11:0] cx;
  logic [11:0] cy;
  logic [7:0]  frame_cnt;
  logic        tick;
  logic        overlap;
  logic [12:0] x_lo, x_hi, y_lo, y_hi, ox, oy;
`ifndef COLLISION_GOD_MODE_EN
  logic [3:0]  hp_after;
`endif

  // Box edges are widened to 13 bits so a cursor near the right/bottom edge does not wrap.
  always_comb begin
    tick    = (hcount_in == 12'd0) && (vcount_in == 12'd0);
    x_lo    = {1'b0, cx};
    y_lo    = {1'b0, cy};
    x_hi    = x_lo + W_SPAN;
    y_hi    = y_lo + H_SPAN;
    ox      = {1'b0, obstacle_x};
    oy      = {1'b0, obstacle_y};
    overlap = ((obstacle_x | obstacle_y) != 12'd0) &&
              (ox >= x_lo) && (ox <= x_hi) &&
              (oy >= y_lo) && (oy <= y_hi);
  end

`ifndef COLLISION_GOD_MODE_EN
  assign hp_after = (hp != 4'd0) ? hp - 4'd1 : 4'd0;
`endif

  // Cursor is sampled once per frame so the box cannot tear mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx <= 12'd0;
      cy <= 12'd0;
    end else if (tick) begin
      cx <= mouse_xpos;
      cy <= mouse_ypos;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      hit          <= 1'b0;
      hp           <= HP_LOAD;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
      frame_cnt    <= 8'd0;
    end else if (!game_on) begin
      state        <= IDLE;
      hit          <= 1'b0;
      hp           <= HP_LOAD;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
      frame_cnt    <= 8'd0;
    end else if (restart) begin
      state        <= ARMED;
      hit          <= 1'b0;
      hp           <= HP_LOAD;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
      frame_cnt    <= 8'd0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          hp           <= HP_LOAD;
          invulnerable <= 1'b0;
          game_over    <= 1'b0;
          state        <= ARMED;
        end
        ARMED: begin
          if (overlap) begin
            hit <= 1'b1;
`ifdef COLLISION_GOD_MODE_EN
            state        <= INVULN;
            invulnerable <= 1'b1;
            frame_cnt    <= FRAMES_LOAD;
`else
            hp <= hp_after;
            if (hp_after == 4'd0) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end else begin
              state        <= INVULN;
              invulnerable <= 1'b1;
              frame_cnt    <= FRAMES_LOAD;
            end
`endif
          end
        end
        INVULN: begin
          invulnerable <= 1'b1;
          if (tick) begin
            if (frame_cnt <= 8'd1) begin
              frame_cnt    <= 8'd0;
              invulnerable <= 1'b0;
              state        <= ARMED;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
            end
          end
        end
        DEAD: begin
          game_over    <= 1'b1;
          hp           <= 4'd0;
          invulnerable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: hits, box boundaries, invulnerability, death, restart, game_on drop.
module tb_collision_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
  logic        game_on, restart;
  logic        hit;
  logic [3:0]  hp;
  logic        invulnerable, game_over;

  int errors = 0;
  int checks = 0;

  collision_detector #(
    .CURSOR_W(12), .CURSOR_H(12), .HP_MAX(3), .INVULN_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .game_on(game_on), .restart(restart),
    .hit(hit), .hp(hp), .invulnerable(invulnerable), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with hcount=vcount=0 so the DUT sees a frame tick and latches the mouse.
  task automatic frame_tick(input logic [11:0] mx, input logic [11:0] my);
    mouse_xpos = mx;
    mouse_ypos = my;
    hcount_in  = 12'd0;
    vcount_in  = 12'd0;
    step();
    hcount_in  = 12'd1;
    vcount_in  = 12'd1;
  endtask

  task automatic set_obs(input logic [11:0] x, input logic [11:0] y);
    obstacle_x = x;
    obstacle_y = y;
  endtask

  initial begin
    rst = 1'b0; game_on = 1'b0; restart = 1'b0;
    hcount_in = 12'd1; vcount_in = 12'd1;
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    step(); step(); step();
    check("rst_hp", 16'(hp), 16'd3);
    check("rst_hit", 16'(hit), 16'd0);
    check("rst_inv", 16'(invulnerable), 16'd0);
    check("rst_go", 16'(game_over), 16'd0);
    rst = 1'b1;

    game_on = 1'b1;
    step();
    check("arm_hp", 16'(hp), 16'd3);
    check("arm_hit", 16'(hit), 16'd0);
    check("arm_go", 16'(game_over), 16'd0);

    frame_tick(12'd100, 12'd200);
    set_obs(12'd112, 12'd205); step();
    check("x112_hit", 16'(hit), 16'd0);
    set_obs(12'd99, 12'd205); step();
    check("x99_hit", 16'(hit), 16'd0);
    set_obs(12'd105, 12'd212); step();
    check("y212_hit", 16'(hit), 16'd0);
    check("miss_hp", 16'(hp), 16'd3);

    set_obs(12'd105, 12'd205); step();
    check("hit1", 16'(hit), 16'd1);
    check("hit1_hp", 16'(hp), 16'd2);
    check("hit1_inv", 16'(invulnerable), 16'd1);
    step();
    check("inv_nohit_a", 16'(hit), 16'd0);
    step();
    check("inv_nohit_b", 16'(hit), 16'd0);
    check("inv_hp", 16'(hp), 16'd2);
    frame_tick(12'd100, 12'd200);
    check("tick1_inv", 16'(invulnerable), 16'd1);
    check("tick1_hit", 16'(hit), 16'd0);
    step();
    check("inv_nohit_c", 16'(hit), 16'd0);
    frame_tick(12'd100, 12'd200);
    check("tick2_inv", 16'(invulnerable), 16'd0);
    check("tick2_hit", 16'(hit), 16'd0);
    check("tick2_hp", 16'(hp), 16'd2);

    set_obs(12'd111, 12'd211); step();
    check("hit2", 16'(hit), 16'd1);
    check("hit2_hp", 16'(hp), 16'd1);
    check("hit2_inv", 16'(invulnerable), 16'd1);
    set_obs(12'd0, 12'd0); step();
    check("hit2_pulse", 16'(hit), 16'd0);
    frame_tick(12'd100, 12'd200);
    frame_tick(12'd100, 12'd200);
    check("rearm2_inv", 16'(invulnerable), 16'd0);

    set_obs(12'd100, 12'd200); step();
    check("hit3", 16'(hit), 16'd1);
    check("hit3_hp", 16'(hp), 16'd0);
    check("hit3_go", 16'(game_over), 16'd1);
    check("hit3_inv", 16'(invulnerable), 16'd0);
    set_obs(12'd105, 12'd205); step(); step();
    check("dead_hit", 16'(hit), 16'd0);
    check("dead_hp", 16'(hp), 16'd0);
    check("dead_go", 16'(game_over), 16'd1);

    // Restart from DEAD with an overlap present: no hit, HP reloaded.
    restart = 1'b1; step(); restart = 1'b0;
    check("rs_hit", 16'(hit), 16'd0);
    check("rs_hp", 16'(hp), 16'd3);
    check("rs_go", 16'(game_over), 16'd0);
    step();
    check("rs_armed_hit", 16'(hit), 16'd1);
    check("rs_armed_hp", 16'(hp), 16'd2);
    restart = 1'b1; step(); restart = 1'b0;
    check("rs_inv_clr", 16'(invulnerable), 16'd0);
    check("rs_inv_hp", 16'(hp), 16'd3);
    restart = 1'b1; step(); restart = 1'b0;
    check("rs_ovl_hit", 16'(hit), 16'd0);
    check("rs_ovl_hp", 16'(hp), 16'd3);
    step();
    check("post_rs_hit", 16'(hit), 16'd1);
    check("post_rs_inv", 16'(invulnerable), 16'd1);

    set_obs(12'd0, 12'd0);
    game_on = 1'b0; step();
    check("off_inv", 16'(invulnerable), 16'd0);
    check("off_hp", 16'(hp), 16'd3);
    check("off_hit", 16'(hit), 16'd0);

    // Right-edge box must not wrap: cx=4090 covers 4090..4101.
    game_on = 1'b1; step();
    frame_tick(12'd4090, 12'd10);
    set_obs(12'd4095, 12'd22); step();
    check("edge_y22_hit", 16'(hit), 16'd0);
    set_obs(12'd4095, 12'd21); step();
    check("edge_hit", 16'(hit), 16'd1);
    check("edge_hp", 16'(hp), 16'd2);
    set_obs(12'd0, 12'd0);

    // Origin cursor: (0,0) means no obstacle, (0,1) is a real pixel.
    game_on = 1'b0; step();
    game_on = 1'b1; step();
    frame_tick(12'd0, 12'd0);
    set_obs(12'd0, 12'd0); step();
    check("zero_nohit", 16'(hit), 16'd0);
    set_obs(12'd0, 12'd1); step();
    check("origin_hit", 16'(hit), 16'd1);
    set_obs(12'd0, 12'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
